alu_cmd_seq: RTL and testbench
==============================

# alu_cmd_seq

Sequential command front-end for the team's 4-bit combinational ALU. Accepts operation commands over a valid/ready handshake and drives the ALU operand and opcode inputs from registers. Captures the ALU result and flags one cycle later and returns them over a valid/ready response channel. Also keeps a 4-bit accumulator for chained operations and a saturating overflow counter.

## Interface

Parameters:

- WIDTH, 4, operand/result width; must match the ALU.
- OVF_CNT_W, 8, width of the overflow event counter.

Ports (one clock; reset is synchronous and active-high):

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  opcode:
  - 000 add, 001 sub, 011 and, 100 or, 101 xor, 110 signed less-than.
  - 010 and 111 are reserved.
- cmd_a  in  WIDTH  operand A; ignored when cmd_acc=1.
- cmd_b  in  WIDTH  operand B.
- cmd_acc  in  1  use the accumulator as operand A.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_ch  out  3  registered opcode to the ALU.
- alu_f  in  WIDTH  ALU result.
- zero_f  in  1  ALU zero flag.
- over_f  in  1  ALU signed-overflow flag.
- cout_f  in  1  ALU carry-out flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_f  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_over  out  1  captured overflow flag.
- rsp_cout  out  1  captured carry-out flag.
- rsp_err  out  1  reserved opcode was issued; result is invalid.
- acc  out  WIDTH  accumulator.
- ovf_cnt  out  OVF_CNT_W  saturating count of captured over_f=1 events.

## Operation

- FSM states: IDLE, EXEC, RESP.
- cmd_ready = (state==IDLE). rsp_valid = (state==RESP). Both are derived from state only; no combinational path from cmd_valid or rsp_ready.
- IDLE, cmd_valid=1:
  - Legal op: alu_a <= (cmd_acc ? acc : cmd_a); alu_b <= cmd_b; alu_ch <= cmd_op; go to EXEC.
  - Reserved op (010, 111): alu_a, alu_b and alu_ch are unchanged; rsp_f, rsp_zero, rsp_over, rsp_cout <= 0; rsp_err <= 1; go to RESP.
- EXEC (exactly one cycle): the ALU output settles from the registered inputs.
  - At the end of the cycle: rsp_f <= alu_f, rsp_zero <= zero_f, rsp_over <= over_f, rsp_cout <= cout_f, rsp_err <= 0; go to RESP.
  - If over_f=1 and ovf_cnt is below its maximum, ovf_cnt increments.
- RESP: all rsp_* outputs are held stable until rsp_ready=1.
  - On rsp_ready=1: if rsp_err=0, acc <= rsp_f; go to IDLE.
  - Error responses never modify acc.
- Flags are passed through unmodified. The block does not reinterpret cout for subtract or compare operations.
- alu_a, alu_b and alu_ch keep their last values outside EXEC, so the ALU inputs do not toggle while idle.
- ovf_cnt saturates at 2^OVF_CNT_W-1 and never wraps. It is cleared only by rst.

## Timing

- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, and every other output = 0 (alu_a, alu_b, alu_ch, rsp_f, all rsp flags, rsp_err, acc, ovf_cnt).
- rst has priority over every transition. Asserting rst in EXEC or RESP drops the in-flight command or pending response without a handshake and clears acc and ovf_cnt.
- Legal op accepted at edge k: alu_* update at k, capture at k+1, rsp_valid high from k+1. Latency is 1 cycle from accept to rsp_valid.
- Reserved op accepted at edge k: rsp_valid high from k, with rsp_err=1.
- Response consumed at edge m: cmd_ready high from m. The next accept is at m+1 at the earliest, so maximum throughput is one legal op per 3 cycles.
- A command with cmd_acc=1 sees the acc value written by the previous response handshake. That write occurs before any later accept.
- cmd_valid held high while cmd_ready=0 is not consumed. The command is accepted on the first IDLE cycle.

## Test plan

All scenarios use the team ALU (or an equivalent model) connected to alu_*.

- Add overflow: op=000, a=0111, b=0001 -> rsp_f=1000, rsp_over=1, rsp_cout=0, rsp_zero=0; ovf_cnt 0->1; after rsp handshake, acc=1000.
- Sub to zero: op=001, a=0011, b=0011 -> rsp_f=0000, rsp_zero=1, rsp_cout=1, rsp_over=0.
- Signed less-than and accumulator chaining:
  - First command: op=110, a=1110, b=0001 -> rsp_f=0001.
  - Then op=000, cmd_acc=1, cmd_a=1111, b=0010 -> alu_a=0001 and rsp_f=0011.
- Reserved op with backpressure: op=111, rsp_ready=0 for 5 cycles.
  - Required: rsp_valid and rsp_err=1 held stable for all 5 cycles, cmd_ready=0 throughout, alu_* unchanged.
  - After the handshake: acc unchanged and cmd_ready=1 next cycle.
- Reset mid-operation: assert rst during EXEC of an add.
  - Required: next cycle state=IDLE, rsp_valid=0, and all outputs at reset values.
  - The dropped command never appears on the response channel.
- Saturation: with OVF_CNT_W=2, issue 5 overflowing adds (0111+0001) -> ovf_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/alu_cmd_seq.sv
// Command front-end for the 4-bit combinational ALU: registers operands/opcode,
// captures result and flags one cycle later, and keeps an accumulator and an overflow count.
module alu_cmd_seq #(
  parameter int WIDTH     = 4,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic                 cmd_acc,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_ch,
  input  logic [WIDTH-1:0]     alu_f,
  input  logic                 zero_f,
  input  logic                 over_f,
  input  logic                 cout_f,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_f,
  output logic                 rsp_zero,
  output logic                 rsp_over,
  output logic                 rsp_cout,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     acc,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic             zero;
    logic             over;
    logic             cout;
    logic             err;
  } rsp_t;

  localparam logic [OVF_CNT_W-1:0] OVF_MAX = '1;

  state_t state;
  rsp_t   rsp_q;
  logic   cmd_rsvd;

  assign cmd_rsvd  = (cmd_op == 3'b010) || (cmd_op == 3'b111);
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  assign rsp_f    = rsp_q.f;
  assign rsp_zero = rsp_q.zero;
  assign rsp_over = rsp_q.over;
  assign rsp_cout = rsp_q.cout;
  assign rsp_err  = rsp_q.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_ch  <= '0;
      rsp_q   <= '0;
      acc     <= '0;
      ovf_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_rsvd) begin
            // ALU inputs stay put; the error response is produced without an ALU pass
            rsp_q <= '{f: '0, zero: 1'b0, over: 1'b0, cout: 1'b0, err: 1'b1};
            state <= RESP;
          end else begin
            alu_a  <= cmd_acc ? acc : cmd_a;
            alu_b  <= cmd_b;
            alu_ch <= cmd_op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_q <= '{f: alu_f, zero: zero_f, over: over_f, cout: cout_f, err: 1'b0};
          if (over_f && ovf_cnt != OVF_MAX) ovf_cnt <= ovf_cnt + 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          if (!rsp_q.err) acc <= rsp_q.f;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: behavioural ALU on alu_*, directed table, corner sequences
// and randomized commands against an accumulator/overflow-count reference model.
module tb_alu_cmd_seq;

  localparam int W  = 4;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_acc;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_a, cmd_b;
  logic [W-1:0]  alu_a, alu_b, alu_f;
  logic [2:0]    alu_ch;
  logic          zero_f, over_f, cout_f;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_f;
  logic          rsp_zero, rsp_over, rsp_cout, rsp_err;
  logic [W-1:0]  acc;
  logic [OW-1:0] ovf_cnt;

  alu_cmd_seq #(.WIDTH(W), .OVF_CNT_W(OW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ch(alu_ch),
    .alu_f(alu_f), .zero_f(zero_f), .over_f(over_f), .cout_f(cout_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_zero(rsp_zero), .rsp_over(rsp_over), .rsp_cout(rsp_cout),
    .rsp_err(rsp_err), .acc(acc), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] f;
    logic       z;
    logic       o;
    logic       c;
  } res_t;

  // Arithmetic ALU model on plain integers
  function automatic res_t alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, r, s;
    res_t x;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    x = '0; r = 0;
    case (op)
      3'd0: begin r = ua + ub; s = sa + sb; x.c = (r > 15); x.o = (s > 7) || (s < -8); end
      3'd1: begin r = ua - ub; s = sa - sb; x.c = (ua >= ub); x.o = (s > 7) || (s < -8); end
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      3'd6: r = (sa < sb) ? 1 : 0;
      default: r = 0;
    endcase
    x.f = r[3:0];
    x.z = (x.f == 4'd0);
    return x;
  endfunction

  always_comb begin
    res_t y;
    y = alu_ref(alu_ch, alu_a, alu_b);
    alu_f  = y.f;
    zero_f = y.z;
    over_f = y.o;
    cout_f = y.c;
  end

  int checks = 0;
  int errors = 0;
  logic [3:0] m_acc = '0;
  int         m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command at a negedge, apply d cycles of response backpressure, complete the handshake
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic ua, input int d, output res_t r, output logic e);
    logic [3:0] ea, ha, hb;
    logic [2:0] hc;
    res_t ex;
    logic rsv;
    int n;
    n = 0;
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    check("cmd_ready_idle", cmd_ready, 1);
    rsv = (op == 3'd2) || (op == 3'd7);
    ea  = ua ? m_acc : a;
    ex  = rsv ? res_t'(0) : alu_ref(op, ea, b);
    ha = rsv ? alu_a : ea;
    hb = rsv ? alu_b : b;
    hc = rsv ? alu_ch : op;
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = ua;
    @(negedge clk);
    cmd_valid = 0;
    check("cmd_ready_busy", cmd_ready, 0);
    check("alu_inputs", {alu_a, alu_b, alu_ch}, {ha, hb, hc});
    if (!rsv) begin
      check("exec_no_rsp", rsp_valid, 0);
      if (ex.o && m_cnt < 3) m_cnt++;
      @(negedge clk);
    end
    check("rsp_latency", rsp_valid, 1);
    check("rsp_data", {rsp_f, rsp_zero, rsp_over, rsp_cout, rsp_err}, {ex, rsv});
    check("ovf_cnt", ovf_cnt, m_cnt);
    r = {rsp_f, rsp_zero, rsp_over, rsp_cout};
    e = rsp_err;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, cmd_ready, rsp_f, rsp_zero, rsp_over, rsp_cout, rsp_err, alu_a, alu_b, alu_ch},
                        {1'b1, 1'b0, ex, rsv, ha, hb, hc});
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    if (!rsv) m_acc = ex.f;
    check("after_hs", {cmd_ready, rsp_valid}, 2'b10);
    check("acc", acc, m_acc);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] a, b;
    logic       ua;
    logic [3:0] f;
    logic       z, o, c, err;
  } vec_t;

  vec_t tab[11];
  res_t r;
  logic e;

  task automatic check_reset_state(input string name);
    check(name, {cmd_ready, rsp_valid, alu_a, alu_b, alu_ch, rsp_f, rsp_zero, rsp_over, rsp_cout, rsp_err, acc, ovf_cnt},
                {1'b1, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 4'b0, 4'd0, 2'd0});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0]  = '{3'd0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[1]  = '{3'd1, 4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[2]  = '{3'd6, 4'b1110, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[3]  = '{3'd0, 4'b1111, 4'b0010, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[4]  = '{3'd3, 4'b1100, 4'b1010, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[5]  = '{3'd4, 4'b1100, 4'b0011, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[6]  = '{3'd5, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tab[7]  = '{3'd1, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[8]  = '{3'd1, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0};
    tab[9]  = '{3'd2, 4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[10] = '{3'd6, 4'b0001, 4'b1110, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_acc = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    check_reset_state("reset_state");
    rst = 0;
    @(negedge clk);

    foreach (tab[i]) begin
      issue(tab[i].op, tab[i].a, tab[i].b, tab[i].ua, i % 3, r, e);
      check($sformatf("tab%0d", i), {r, e}, {tab[i].f, tab[i].z, tab[i].o, tab[i].c, tab[i].err});
    end

    // Reserved op under 5 cycles of backpressure; acc must survive
    issue(3'd7, 4'b1010, 4'b0101, 1'b0, 5, r, e);
    check("rsvd_err", e, 1);

    // Reset during EXEC of an add: command is dropped, everything returns to reset values
    cmd_valid = 1; cmd_op = 3'd0; cmd_a = 4'b0111; cmd_b = 4'b0001; cmd_acc = 0;
    @(negedge clk);
    cmd_valid = 0;
    check("mid_exec", {cmd_ready, rsp_valid}, 2'b00);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_reset_state("reset_mid_exec");
    m_acc = '0; m_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      check("dropped_no_rsp", rsp_valid, 0);
    end

    // Saturation of the 2-bit overflow counter: 1,2,3,3,3
    for (int k = 0; k < 5; k++) begin
      issue(3'd0, 4'b0111, 4'b0001, 1'b0, 0, r, e);
      check($sformatf("sat%0d", k), ovf_cnt, (k < 3) ? k + 1 : 3);
    end

    for (int k = 0; k < 150; k++)
      issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3), r, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
